// File: rtl/adc_sample_sequencer_pkg.sv
// Shared constants and state encoding for the ADC sample path
// (sequencer, truncator and PWM blocks).
package adc_sample_sequencer_pkg;

  localparam int unsigned ADC_CLK_DIV      = 4;
  localparam int unsigned ADC_FRAME_BITS   = 16;
  localparam int unsigned ADC_DATA_BITS    = 12;
  localparam int unsigned ADC_QUIET_CYCLES = 8;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_FRAME = 2'd1,
    SEQ_DONE  = 2'd2,
    SEQ_QUIET = 2'd3
  } seq_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// SCLK generator: divides the master clock into an SCLK that idles high
// and reports the cycle in which SCLK is about to rise or fall.
module adc_sclk_gen
  import adc_sample_sequencer_pkg::*;
#(
  parameter int unsigned CLK_DIV = ADC_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic sclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int unsigned   DW       = cnt_width(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          terminal;

  // Strobes are valid in the cycle whose closing edge toggles sclk, so the
  // consumer samples on the same edge the external clock rises.
  assign terminal  = enable && !clear && (div_cnt == DIV_LAST);
  assign rise_tick = terminal && !sclk;
  assign fall_tick = terminal && sclk;

  // Half-period counter; sclk toggles and the counter wraps at terminal count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      sclk    <= 1'b1;
    end else if (clear) begin
      div_cnt <= '0;
      sclk    <= 1'b1;
    end else if (enable) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        sclk    <= ~sclk;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/adc_sample_sequencer.sv
// Serial ADC sequencer: frames conversions with CS/SCLK, shifts in SDATA,
// and presents the sample over valid/ready with sticky overrun detection.
module adc_sample_sequencer
  import adc_sample_sequencer_pkg::*;
#(
  parameter int unsigned CLK_DIV      = ADC_CLK_DIV,
  parameter int unsigned FRAME_BITS   = ADC_FRAME_BITS,
  parameter int unsigned DATA_BITS    = ADC_DATA_BITS,
  parameter int unsigned QUIET_CYCLES = ADC_QUIET_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 start,
  input  logic                 clr_overrun,
  input  logic                 sdata,
  input  logic                 sample_ready,
  output logic                 sclk,
  output logic                 cs,
  output logic [DATA_BITS-1:0] sample,
  output logic                 sample_valid,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned   BW         = cnt_width(FRAME_BITS);
  localparam int unsigned   QW         = cnt_width(QUIET_CYCLES);
  localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);
  localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_CYCLES - 1);

  seq_state_e            state;
  logic [BW-1:0]         bit_cnt;
  logic [QW-1:0]         quiet_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  gen_en;
  logic                  gen_clr;
  logic                  rise_tick;
  logic                  fall_tick;

  // The divider only runs inside a frame; everywhere else it is held at
  // sclk=1 with a zero count so every frame starts with a full half-period.
  assign gen_en  = (state == SEQ_FRAME);
  assign gen_clr = !gen_en;

  adc_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .reset     (reset),
    .enable    (gen_en),
    .clear     (gen_clr),
    .sclk      (sclk),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // A single divider terminal count can only ever be one kind of edge.
  a_one_edge : assert property (@(posedge clk) disable iff (!reset)
    !(rise_tick && fall_tick));

  // Frame scheduling FSM plus the output handshake and overrun flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= SEQ_IDLE;
      cs           <= 1'b1;
      busy         <= 1'b0;
      bit_cnt      <= '0;
      quiet_cnt    <= '0;
      shreg        <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      case (state)
        SEQ_IDLE: begin
          if (enable || start) begin
            state   <= SEQ_FRAME;
            cs      <= 1'b0;
            busy    <= 1'b1;
            bit_cnt <= '0;
            shreg   <= '0;
          end
        end
        SEQ_FRAME: begin
          if (rise_tick) begin
            shreg <= {shreg[FRAME_BITS-2:0], sdata};
            if (bit_cnt == BIT_LAST) begin
              state   <= SEQ_DONE;
              cs      <= 1'b1;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        SEQ_DONE: begin
          state     <= SEQ_QUIET;
          quiet_cnt <= '0;
        end
        SEQ_QUIET: begin
          if (quiet_cnt == QUIET_LAST) begin
            if (enable) begin
              state   <= SEQ_FRAME;
              cs      <= 1'b0;
              bit_cnt <= '0;
              shreg   <= '0;
            end else begin
              state <= SEQ_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            quiet_cnt <= quiet_cnt + QW'(1);
          end
        end
        default: begin
          state <= SEQ_IDLE;
          cs    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase

      // DONE loads the new sample even if the old one was accepted in the
      // same cycle; otherwise an accept simply retires the pending sample.
      if (state == SEQ_DONE) begin
        sample       <= shreg[DATA_BITS-1:0];
        sample_valid <= 1'b1;
      end else if (sample_ready) begin
        sample_valid <= 1'b0;
      end

      // Set has priority over clear.
      if ((state == SEQ_DONE) && sample_valid && !sample_ready) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Self-checking bench for adc_sample_sequencer: a frame-timeline model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_adc_sample_sequencer;

  localparam int C  = 4;
  localparam int FB = 16;
  localparam int DB = 12;
  localparam int Q  = 8;
  localparam int L  = 2 * FB * C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, enable, start, clr_overrun, sdata, sample_ready;
  logic          sclk, cs, sample_valid, overrun, busy;
  logic [DB-1:0] sample;

  logic          b_enable, b_start, b_clr, b_sdata, b_ready;
  logic          b_sclk, b_cs, b_valid, b_overrun, b_busy;
  logic [DB-1:0] b_sample;

  adc_sample_sequencer dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start),
    .clr_overrun(clr_overrun), .sdata(sdata), .sample_ready(sample_ready),
    .sclk(sclk), .cs(cs), .sample(sample), .sample_valid(sample_valid),
    .overrun(overrun), .busy(busy)
  );

  adc_sample_sequencer #(.CLK_DIV(1)) dut_div1 (
    .clk(clk), .reset(reset), .enable(b_enable), .start(b_start),
    .clr_overrun(b_clr), .sdata(b_sdata), .sample_ready(b_ready),
    .sclk(b_sclk), .cs(b_cs), .sample(b_sample), .sample_valid(b_valid),
    .overrun(b_overrun), .busy(b_busy)
  );

  // Model: a frame is a timeline of offsets since CS fell.
  // 0..L-1 CS low, L is the delivery cycle, L+1..L+Q is the quiet gap.
  bit            m_active;
  int            m_p;
  logic [FB-1:0] m_word;
  logic [DB-1:0] m_sample;
  bit            m_valid, m_ovr;
  logic [FB-1:0] wq[$];

  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [FB-1:0] next_word();
    if (wq.size() > 0) return wq.pop_front();
    return FB'($urandom);
  endfunction

  task automatic model_step();
    bit done_now;
    bit ov_set;
    if (!reset) begin
      m_active = 0; m_p = 0; m_valid = 0; m_ovr = 0; m_sample = '0;
      return;
    end
    done_now = m_active && (m_p == L);
    ov_set   = done_now && m_valid && !sample_ready;
    if (done_now) begin
      m_sample = m_word[DB-1:0];
      m_valid  = 1;
    end else if (m_valid && sample_ready) begin
      m_valid = 0;
    end
    if (ov_set) m_ovr = 1;
    else if (clr_overrun) m_ovr = 0;
    if (!m_active) begin
      if (enable || start) begin
        m_active = 1; m_p = 0; m_word = next_word();
      end
    end else if (m_p == L + Q) begin
      if (enable) begin
        m_p = 0; m_word = next_word();
      end else begin
        m_active = 0;
      end
    end else begin
      m_p++;
    end
  endtask

  task automatic compare();
    bit in_frame;
    bit exp_sclk;
    in_frame = m_active && (m_p < L);
    exp_sclk = in_frame ? (((m_p / C) % 2) == 0) : 1'b1;
    chk("cs", cs, !in_frame);
    chk("sclk", sclk, exp_sclk);
    chk("busy", busy, m_active);
    chk("sample_valid", sample_valid, m_valid);
    chk("overrun", overrun, m_ovr);
    chk("sample", sample, m_sample);
  endtask

  // ADC model: next bit appears after each SCLK falling edge, MSB first.
  task automatic drive_sdata();
    int bitpos;
    if (m_active && (m_p < L)) begin
      bitpos = (m_p < C) ? 0 : (m_p - C) / (2 * C);
      sdata  = m_word[FB-1-bitpos];
    end else begin
      sdata = 1'($urandom);
    end
  endtask

  task automatic do_cycle();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    compare();
    drive_sdata();
  endtask

  initial begin
    int     cs_low, rises, nfall, nsamp, ndone, extra;
    bit     prev_sclk, prev_cs, post2, post3;
    longint tf[3];
    logic [DB-1:0] got[3];
    logic [FB-1:0] b_word;

    reset = 1; enable = 0; start = 0; clr_overrun = 0; sdata = 0; sample_ready = 0;
    b_enable = 0; b_start = 0; b_clr = 0; b_sdata = 0; b_ready = 0;
    m_active = 0; m_p = 0; m_valid = 0; m_ovr = 0; m_sample = '0; m_word = '0;
    #2 reset = 0;
    repeat (3) do_cycle();
    chk("reset_cs", cs, 1);
    chk("reset_sclk", sclk, 1);
    reset = 1;
    repeat (2) do_cycle();

    // Single shot, 0000_1010_0101_1100.
    wq.push_back(16'h0A5C);
    start = 1; do_cycle(); start = 0;
    cs_low = 0; rises = 0; prev_sclk = 1;
    for (int i = 0; i <= 140; i++) begin
      if (cs === 1'b0) cs_low++;
      if (prev_sclk == 0 && sclk === 1'b1) rises++;
      prev_sclk = sclk;
      if (i == 128) chk("t1_valid_early", sample_valid, 0);
      if (i == 129) begin
        chk("t1_latency_valid", sample_valid, 1);
        chk("t1_sample", sample, 12'hA5C);
      end
      if (i == 136) chk("t1_busy_quiet", busy, 1);
      if (i == 137) chk("t1_busy_idle", busy, 0);
      do_cycle();
    end
    chk("t1_cs_low_cycles", cs_low, 128);
    chk("t1_sclk_rises", rises, 16);
    sample_ready = 1; do_cycle(); sample_ready = 0;

    // Continuous conversion, ready tied high.
    wq.push_back(16'h0001); wq.push_back(16'h0FFF); wq.push_back(16'h0800);
    sample_ready = 1; enable = 1;
    nfall = 0; nsamp = 0; prev_cs = 1;
    for (int i = 0; i < 700; i++) begin
      if (prev_cs && cs === 1'b0) begin
        if (nfall < 3) tf[nfall] = cyc;
        nfall++;
        if (nfall == 3) enable = 0;
      end
      prev_cs = cs;
      if (sample_valid === 1'b1 && nsamp < 3) begin
        got[nsamp] = sample;
        nsamp++;
      end
      if (nfall >= 3 && busy === 1'b0) break;
      do_cycle();
    end
    chk("t2_terminated", busy, 0);
    chk("t2_frames", nfall, 3);
    chk("t2_period_1", 32'(tf[1] - tf[0]), 137);
    chk("t2_period_2", 32'(tf[2] - tf[1]), 137);
    chk("t2_sample_0", got[0], 12'h001);
    chk("t2_sample_1", got[1], 12'hFFF);
    chk("t2_sample_2", got[2], 12'h800);
    chk("t2_no_overrun", overrun, 0);

    // Overrun: ready low for consecutive frames, clear colliding with DONE.
    wq.push_back(16'hF123); wq.push_back(16'h0456); wq.push_back(16'h0789);
    sample_ready = 0; enable = 1; ndone = 0; post2 = 0; post3 = 0;
    for (int i = 0; i < 700; i++) begin
      do_cycle();
      if (post2) begin
        chk("t3_overrun_set", overrun, 1);
        chk("t3_sample_second", sample, 12'h456);
        post2 = 0;
      end
      if (post3) begin
        chk("t3_set_wins", overrun, 1);
        chk("t3_sample_third", sample, 12'h789);
        post3 = 0;
      end
      clr_overrun = 0;
      if (m_active && m_p == L) begin
        ndone++;
        if (ndone == 1) chk("t3_first_no_overrun", overrun, 0);
        if (ndone == 2) post2 = 1;
        if (ndone == 3) begin clr_overrun = 1; enable = 0; post3 = 1; end
      end
      if (ndone == 3 && !post3 && !m_active) break;
    end
    chk("t3_done_count", ndone, 3);
    clr_overrun = 1; do_cycle(); clr_overrun = 0;
    chk("t3_cleared", overrun, 0);

    // Async reset at offset 60 of a frame, sample still pending.
    start = 1; do_cycle(); start = 0;
    repeat (60) do_cycle();
    #2 reset = 0;
    #1;
    chk("t4_async_cs", cs, 1);
    chk("t4_async_sclk", sclk, 1);
    chk("t4_async_valid", sample_valid, 0);
    chk("t4_async_busy", busy, 0);
    repeat (2) do_cycle();
    reset = 1;
    do_cycle();
    wq.push_back(16'hB7E1);
    start = 1; do_cycle(); start = 0;
    for (int i = 0; i <= 140; i++) begin
      if (i == 129) chk("t4_clean_sample", sample, 12'h7E1);
      do_cycle();
    end

    // start while busy is ignored.
    sample_ready = 1;
    start = 1; do_cycle(); start = 0;
    extra = 0; prev_cs = 0;
    for (int i = 0; i <= 150; i++) begin
      start = (i == 30 || i == 136);
      if (prev_cs && cs === 1'b0) extra++;
      prev_cs = cs;
      if (i == 137) chk("t5_idle_after_quiet", busy, 0);
      do_cycle();
    end
    start = 0;
    chk("t5_no_extra_frame", extra, 0);

    // enable dropped at offset 50: frame still delivers, then idle.
    enable = 1; do_cycle();
    for (int i = 0; i <= 145; i++) begin
      if (i == 50) enable = 0;
      if (i == 129) chk("t5_drop_delivers", sample_valid, 1);
      if (i == 137) chk("t5_drop_idle", busy, 0);
      if (i == 145) chk("t5_drop_cs_high", cs, 1);
      do_cycle();
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      start        = ($urandom_range(0, 29) == 0);
      sample_ready = $urandom_range(0, 1) == 1;
      clr_overrun  = ($urandom_range(0, 15) == 0);
      do_cycle();
    end
    enable = 0; start = 0; clr_overrun = 0; sample_ready = 1;
    repeat (L + Q + 4) do_cycle();
    chk("rand_idle", busy, 0);

    // CLK_DIV=1 build: one-cycle half period, 33-cycle latency.
    b_word = 16'h3C96;
    b_start = 1; do_cycle(); b_start = 0;
    for (int i = 0; i <= 40; i++) begin
      if (i < 32) begin
        chk("b_sclk", b_sclk, (i % 2) == 0);
        chk("b_cs", b_cs, 0);
        b_sdata = b_word[FB-1-((i < 1) ? 0 : (i - 1) / 2)];
      end
      if (i == 0) chk("b_busy", b_busy, 1);
      if (i == 32) begin
        chk("b_cs_done", b_cs, 1);
        chk("b_valid_early", b_valid, 0);
      end
      if (i == 33) begin
        chk("b_latency_valid", b_valid, 1);
        chk("b_sample", b_sample, 12'hC96);
      end
      do_cycle();
    end
    chk("b_overrun", b_overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_sample_sequencer.md
Name: adc_sample_sequencer

Overview:
Controller that sequences the serial ADC front end. It generates CS and SCLK from the master clock, frames each 16-bit conversion and shifts in SDATA. It extracts the 12-bit sample and hands it to the downstream truncator/PWM path over a valid/ready handshake. It replaces free-running divider framing with single-shot or continuous conversion scheduling and overrun detection.

Parameters:
CLK_DIV, 4, master-clock cycles per SCLK half-period (>=1)
FRAME_BITS, 16, SCLK periods per conversion frame
DATA_BITS, 12, sample width; the sample is the last DATA_BITS bits of the frame
QUIET_CYCLES, 8, minimum master-clock cycles CS stays high between frames (>=1)

Ports:
clk  in  1  master clock
reset  in  1  asynchronous reset, active-low
enable  in  1  continuous conversion while high
start  in  1  single-shot request, one-cycle pulse
clr_overrun  in  1  clears the overrun flag
sdata  in  1  ADC serial data
sample_ready  in  1  downstream accepts sample
sclk  out  1  ADC serial clock, idles high
cs  out  1  ADC chip select, active-low
sample  out  DATA_BITS  last captured sample
sample_valid  out  1  sample pending
overrun  out  1  sticky: an unaccepted sample was overwritten
busy  out  1  high in FRAME, DONE and QUIET

Behaviour:
- Reset (reset=0, async): state IDLE, cs=1, sclk=1, sample=0, sample_valid=0, overrun=0, busy=0, counters and shift register cleared. Reset mid-frame aborts immediately; the partial frame is discarded.
- States: IDLE, FRAME, DONE, QUIET.
- IDLE -> FRAME when enable=1 or start=1. cs goes 0 and sclk stays 1 on the entry cycle.
- FRAME: div_cnt counts 0..CLK_DIV-1. At the terminal count, sclk toggles and div_cnt wraps.
  - On each internal 0->1 sclk transition, sdata is shifted MSB-first into a FRAME_BITS shift register and bit_cnt increments.
  - After the FRAME_BITS-th rising edge (exactly 2*FRAME_BITS*CLK_DIV cycles after entry), go to DONE.
- DONE (1 cycle): cs=1, sclk=1. sample <= shift register [DATA_BITS-1:0], sample_valid <= 1.
  - If sample_valid=1 and sample_ready=0 in this cycle, the old sample is overwritten and overrun is set.
  - If sample_ready=1 in the same cycle, the old sample is accepted, the new one loads and there is no overrun.
- QUIET: cs=1 for QUIET_CYCLES cycles. Then go to FRAME if enable=1, else IDLE.
- Latency: CS falling edge to sample_valid is 2*FRAME_BITS*CLK_DIV+1 cycles, i.e. 129 at defaults.
- Continuous period: 2*FRAME_BITS*CLK_DIV+1+QUIET_CYCLES, i.e. 137 at defaults.
- start while busy is ignored (not queued).
- enable dropped mid-frame: the frame completes and is delivered; QUIET is then followed by IDLE.
- Handshake: sample_valid is held until a cycle with sample_ready=1, then cleared next cycle unless DONE reloads it. sample is stable while valid.
- overrun: cleared by clr_overrun; if set and clear occur in the same cycle, set wins.
- busy = (state != IDLE).

Decomposition:
- Shared constants header: FRAME_BITS, DATA_BITS, CLK_DIV, QUIET_CYCLES defaults and the state encoding (2-bit: IDLE=0, FRAME=1, DONE=2, QUIET=3), reused by the truncator and PWM blocks.
- One natural sub-module, adc_sclk_gen: the div_cnt/sclk toggle logic. It has enable and clear inputs, and outputs sclk plus single-cycle rise_tick/fall_tick strobes.

Test Plan:
- Single-shot, sdata stream 0000_1010_0101_1100 driven on sclk falling edges, start pulse -> cs low for 128 cycles, 16 sclk rising edges, sample=0xA5C and sample_valid=1 at cycle 129, busy low after cycle 137.
- Continuous with enable=1 and sample_ready tied high -> cs falling edges exactly 137 cycles apart; successive samples 0x001, 0xFFF and 0x800 delivered in order; overrun stays 0.
- sample_ready=0 for two frames -> second DONE sets overrun=1 and sample shows the second value; clr_overrun pulse in the same cycle as a third DONE -> overrun remains 1.
- Reset asserted at cycle 60 of a frame -> cs=1, sclk=1, sample_valid=0 asynchronously; after release, a new start yields a correct full sample with no residue from the aborted frame.
- start pulsed during FRAME and during QUIET -> no extra frame; enable dropped at cycle 50 -> that frame still delivers and the block returns to IDLE after QUIET.
- CLK_DIV=1 build -> sclk half-period of 1 cycle; latency 33 cycles; sample correct.
